// File: rtl/udp_pack_p.sv
// udp_pack_p: buffers framed payload bytes, admits or drops whole packets,
// and emits each committed packet behind an 8-byte UDP header with pseudo-header checksum.
module udp_pack_p #(
    parameter int DATA_DEPTH = 2048,
    parameter int MSG_DEPTH  = 16,
    parameter int MAX_LEN    = 1472,
    parameter bit CSUM_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dest_port,
    input  logic [15:0] sour_port,
    input  logic [31:0] dest_ip,
    input  logic [31:0] sour_ip,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    input  logic        dout_rdy,
    output logic [15:0] drop_cnt
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int MW = $clog2(MSG_DEPTH);
    typedef enum logic [1:0] {WAIT_SOP, ACCEPT, DISCARD} ist_t;
    typedef enum logic [1:0] {IDLE, HEAD, PAY} est_t;

    logic [8:0]  r_mem  [DATA_DEPTH];
    logic [63:0] r_dmem [MSG_DEPTH];
    ist_t        r_ist;
    est_t        r_est;
    logic [AW:0] r_wp, r_cp, r_rp;
    logic [MW:0] r_mwp, r_mrp;
    logic [15:0] r_len, r_sport, r_dport, r_drop;
    logic [31:0] r_sum, r_sip, r_dip;
    logic [7:0]  r_dout;
    logic        r_vld, r_sop, r_eop;
    logic [2:0]  r_hc;

    logic [AW:0] w_used, w_wa;
    logic [MW:0] w_mused;
    logic        w_mfull, w_abort, w_new, w_admit, w_refuse, w_over, w_wr, w_commit, w_adv, w_dempty;
    logic [15:0] w_len_base, w_len_n, w_ulen, w_sport, w_dport, w_f2, w_csum;
    logic [31:0] w_sum_base, w_sum_n, w_sip, w_dip, w_tot, w_f1;
    logic [1:0]  w_drops;
    logic [16:0] w_dsum;
    logic [63:0] w_desc;
    logic [8:0]  w_pb;
    ist_t        w_ist_n;

    // Admission looks at committed occupancy so a mid-packet sop sees the rolled-back space
    assign w_used   = r_cp - r_rp;
    assign w_mused  = r_mwp - r_mrp;
    assign w_mfull  = w_mused[MW];
    assign w_abort  = din_vld && din_sop && r_ist == ACCEPT;
    assign w_new    = din_vld && din_sop && r_ist != DISCARD;
    assign w_admit  = w_new && !w_mfull && (32'(w_used) + 32'(MAX_LEN) <= 32'(DATA_DEPTH));
    assign w_refuse = w_new && !w_admit;
    assign w_over   = din_vld && !din_sop && r_ist == ACCEPT && r_len == 16'(MAX_LEN);
    assign w_wr     = w_admit || (din_vld && !din_sop && r_ist == ACCEPT && !w_over);
    assign w_commit = w_wr && din_eop;
    assign w_wa     = (w_abort || w_over) ? r_cp : r_wp;
    assign w_drops  = {1'b0, w_abort} + {1'b0, w_over} + {1'b0, w_refuse};
    assign w_dsum   = {1'b0, r_drop} + {15'h0, w_drops};
    assign w_ist_n  = (w_commit || (din_vld && din_eop && !w_wr)) ? WAIT_SOP :
                      w_admit ? ACCEPT : (w_refuse || w_over) ? DISCARD : r_ist;

    assign w_len_base = w_admit ? 16'h0 : r_len;
    assign w_sum_base = w_admit ? 32'h0 : r_sum;
    assign w_len_n    = w_len_base + 16'h1;
    assign w_sum_n    = w_sum_base + (w_len_base[0] ? {24'h0, din} : {16'h0, din, 8'h0});

    // A single-byte packet commits in its sop cycle, before the header fields are latched
    assign w_sport = din_sop ? sour_port : r_sport;
    assign w_dport = din_sop ? dest_port : r_dport;
    assign w_sip   = din_sop ? sour_ip : r_sip;
    assign w_dip   = din_sop ? dest_ip : r_dip;
    assign w_ulen  = w_len_n + 16'd8;
    assign w_tot   = w_sum_n + {16'h0, w_sip[31:16]} + {16'h0, w_sip[15:0]} + {16'h0, w_dip[31:16]}
                   + {16'h0, w_dip[15:0]} + 32'h11 + {16'h0, w_ulen} + {16'h0, w_ulen}
                   + {16'h0, w_sport} + {16'h0, w_dport};
    assign w_f1    = {16'h0, w_tot[31:16]} + {16'h0, w_tot[15:0]};
    assign w_f2    = w_f1[31:16] + w_f1[15:0];
    assign w_csum  = !CSUM_EN ? 16'h0 : (w_f2 == 16'hFFFF) ? 16'hFFFF : ~w_f2;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[w_wa[AW-1:0]] <= {din_eop, din};
        if (w_commit)
            r_dmem[r_mwp[MW-1:0]] <= {w_sport, w_dport, w_ulen, w_csum};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ist   <= WAIT_SOP;
            r_wp    <= '0;
            r_cp    <= '0;
            r_mwp   <= '0;
            r_len   <= '0;
            r_sum   <= '0;
            r_sport <= '0;
            r_dport <= '0;
            r_sip   <= '0;
            r_dip   <= '0;
            r_drop  <= '0;
        end else begin
            r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
            r_ist  <= w_ist_n;
            r_wp   <= w_wr ? w_wa + 1'b1 : w_wa;
            if (w_commit) begin
                r_cp  <= w_wa + 1'b1;
                r_mwp <= r_mwp + 1'b1;
            end
            if (w_wr) begin
                r_len <= w_len_n;
                r_sum <= w_sum_n;
            end
            if (w_admit) begin
                r_sport <= sour_port;
                r_dport <= dest_port;
                r_sip   <= sour_ip;
                r_dip   <= dest_ip;
            end
        end
    end

    assign w_adv    = !r_vld || dout_rdy;
    assign w_dempty = r_mwp == r_mrp;
    assign w_desc   = r_dmem[r_mrp[MW-1:0]];
    assign w_pb     = r_mem[r_rp[AW-1:0]];

    // IDLE emits header byte 0 itself so the first byte lands two cycles after eop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_est  <= IDLE;
            r_rp   <= '0;
            r_mrp  <= '0;
            r_hc   <= '0;
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
        end else if (w_adv) begin
            r_vld <= 1'b0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
            case (r_est)
                IDLE: if (!w_dempty) begin
                    r_dout <= w_desc[63:56];
                    r_vld  <= 1'b1;
                    r_sop  <= 1'b1;
                    r_hc   <= 3'd1;
                    r_est  <= HEAD;
                end
                HEAD: begin
                    r_dout <= w_desc[{3'd7 - r_hc, 3'b000} +: 8];
                    r_vld  <= 1'b1;
                    r_hc   <= r_hc + 3'd1;
                    if (r_hc == 3'd7)
                        r_est <= PAY;
                end
                PAY: begin
                    r_dout <= w_pb[7:0];
                    r_vld  <= 1'b1;
                    r_eop  <= w_pb[8];
                    r_rp   <= r_rp + 1'b1;
                    if (w_pb[8]) begin
                        r_mrp <= r_mrp + 1'b1;
                        r_est <= IDLE;
                    end
                end
                default: r_est <= IDLE;
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_vld;
    assign dout_sop = r_sop;
    assign dout_eop = r_eop;
    assign drop_cnt = r_drop;
endmodule

// File: tb/tb_udp_pack_p.sv
// tb_udp_pack_p: directed vectors against hand-computed UDP frames, checksums and drop counts.
module tb_udp_pack_p;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] dest_port = 16'h5678, sour_port = 16'h1234;
    logic [31:0] dest_ip = 32'hC0A80002, sour_ip = 32'hC0A80001;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0, dout_rdy = 1'b1;
    logic [7:0]  dout, d1;
    logic        dout_vld, dout_sop, dout_eop, d1_vld, d1_sop, d1_eop;
    logic [15:0] drop_cnt, d1_drop;
    int          n_tot = 0, n_bad = 0, cyc = 0, t_eop = 0, t_sop = -1;
    logic [9:0]  got[$], got2[$];
    logic [9:0]  p_out = '0;
    bit          p_stall = 1'b0, tog = 1'b0;
    logic        rdy_set = 1'b1;

    udp_pack_p #(.DATA_DEPTH(64), .MSG_DEPTH(4), .MAX_LEN(16), .CSUM_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .dest_port(dest_port), .sour_port(sour_port), .dest_ip(dest_ip),
        .sour_ip(sour_ip), .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_rdy(dout_rdy), .drop_cnt(drop_cnt));

    udp_pack_p #(.DATA_DEPTH(64), .MSG_DEPTH(4), .MAX_LEN(16), .CSUM_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .dest_port(dest_port), .sour_port(sour_port), .dest_ip(dest_ip),
        .sour_ip(sour_ip), .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
        .dout(d1), .dout_vld(d1_vld), .dout_sop(d1_sop), .dout_eop(d1_eop),
        .dout_rdy(dout_rdy), .drop_cnt(d1_drop));

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1 dout_rdy = tog ? !dout_rdy : rdy_set;
    end

    initial forever begin
        @(negedge clk);
        if (dout_vld && dout_rdy) got.push_back({dout_sop, dout_eop, dout});
        if (d1_vld && dout_rdy) got2.push_back({d1_sop, d1_eop, d1});
        if (dout_vld && dout_sop && t_sop < 0) t_sop = cyc;
        if (p_stall && !rst) check("hold", {22'h0, dout_sop, dout_eop, dout}, {22'h0, p_out});
        p_stall = dout_vld && !dout_rdy && !rst;
        p_out = {dout_sop, dout_eop, dout};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] p[$], input bit eop);
        foreach (p[i]) begin
            @(posedge clk);
            #1;
            din_vld = 1'b1;
            din = p[i];
            din_sop = (i == 0);
            din_eop = eop && (i == p.size() - 1);
            if (din_eop) t_eop = cyc;
        end
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic do_rst();
        tog = 1'b0;
        rdy_set = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_vld", {31'h0, dout_vld}, 32'h0);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_flags", {30'h0, dout_sop, dout_eop}, 32'h0);
        check("rst_drop", {16'h0, drop_cnt}, 32'h0);
        rst = 1'b0;
        got.delete();
        got2.delete();
        t_sop = -1;
    endtask

    task automatic expect_pkt(input string tag, input logic [7:0] e[$]);
        logic [9:0] w;
        int n = 0;
        while (got.size() < e.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, {31'h0, got.size() >= e.size()}, 32'h1);
        foreach (e[i]) begin
            w = got.size() > 0 ? got.pop_front() : 10'h3FF;
            check($sformatf("%s_b%0d", tag, i), {22'h0, w},
                  {22'h0, 1'(i == 0), 1'(i == e.size() - 1), e[i]});
        end
    endtask

    task automatic no_extra(input string tag);
        repeat (30) @(negedge clk);
        check({tag, "_extra"}, got.size(), 0);
    endtask

    logic [7:0] c1[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, 8'h11, 8'hD0,
                          8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] c1n[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, 8'h00, 8'h00,
                           8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] pl1[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] big[$], tmp[$];

    initial begin
        do_rst();
        // Test 1: basic packet, latency, and checksum-disabled twin
        send(pl1, 1'b1);
        expect_pkt("t1", c1);
        check("t1_lat", t_sop - t_eop, 2);
        no_extra("t1");
        check("t1n_count", got2.size(), c1n.size());
        foreach (c1n[i])
            check($sformatf("t1n_b%0d", i), {24'h0, got2.size() > i ? got2[i][7:0] : 8'hEE}, {24'h0, c1n[i]});
        check("t1n_drop", {16'h0, d1_drop}, 32'h0);

        // Test 2: odd-length payload padded low
        do_rst();
        tmp = '{8'hAB};
        send(tmp, 1'b1);
        expect_pkt("t2", '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h09, 8'h6A, 8'hDB, 8'hAB});
        no_extra("t2");

        // Test 3: toggling backpressure, hold checks run in the monitor
        do_rst();
        tog = 1'b1;
        send(pl1, 1'b1);
        expect_pkt("t3", c1);
        tog = 1'b0;
        no_extra("t3");

        // Test 4: oversize packet rolled back, following packet survives
        do_rst();
        big.delete();
        for (int i = 0; i < 20; i++) big.push_back(8'(8'hA0 + i));
        send(big, 1'b1);
        send(pl1, 1'b1);
        expect_pkt("t4", c1);
        no_extra("t4");
        check("t4_drop", {16'h0, drop_cnt}, 32'h1);

        // Test 5: mid-packet sop aborts and restarts
        do_rst();
        tmp = '{8'hAA, 8'hBB, 8'hCC};
        send(tmp, 1'b0);
        send(pl1, 1'b1);
        expect_pkt("t5", c1);
        no_extra("t5");
        check("t5_drop", {16'h0, drop_cnt}, 32'h1);

        // Test 6: descriptor FIFO full under stall, fifth packet dropped
        do_rst();
        rdy_set = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tmp = '{8'(8'h10 + k)};
            send(tmp, 1'b1);
        end
        repeat (5) @(negedge clk);
        check("t6_drop", {16'h0, drop_cnt}, 32'h1);
        check("t6_stalled", got.size(), 0);
        rdy_set = 1'b1;
        for (int k = 0; k < 4; k++)
            expect_pkt($sformatf("t6p%0d", k), '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h09,
                       8'(8'h05 - k), 8'hDC, 8'(8'h10 + k)});
        no_extra("t6");

        // Async reset mid-packet discards the partial packet
        tmp = '{8'h55, 8'h66};
        send(tmp, 1'b0);
        do_rst();
        tmp = '{8'hAB};
        send(tmp, 1'b1);
        expect_pkt("t7", '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h09, 8'h6A, 8'hDB, 8'hAB});
        no_extra("t7");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/udp_pack_p.md
# udp_pack_p

Parametrised UDP encapsulator: accepts a byte-stream payload with sop/eop framing and emits each packet prefixed with an 8-byte UDP header: source port, destination port, length, and a checksum that includes the pseudo-header. It is the next generation of the team's single-shot UDP packer. It adds configurable depths, whole-packet admission and drop with rollback, odd-length checksum padding, optional checksum, and output backpressure. It sits between the payload source and the IP encapsulation stage.

## Interface
- DATA_DEPTH, 2048: payload FIFO depth in bytes (power of 2).
- MSG_DEPTH, 16: descriptor FIFO depth in packets (power of 2).
- MAX_LEN, 1472: maximum payload bytes; must be ≤ DATA_DEPTH.
- CSUM_EN, 1: 1 = compute checksum; 0 = transmit checksum 0x0000.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dest_port  in  16  destination UDP port, sampled with the sop byte.
- sour_port  in  16  source UDP port, sampled with the sop byte.
- dest_ip  in  32  destination IP (pseudo-header), sampled with the sop byte.
- sour_ip  in  32  source IP (pseudo-header), sampled with the sop byte.
- din  in  8  payload byte.
- din_vld  in  1  din valid; no ready, so the source never stalls.
- din_sop  in  1  first byte of packet, qualified by din_vld.
- din_eop  in  1  last byte of packet, qualified by din_vld.
- dout  out  8  output byte.
- dout_vld  out  1  dout valid.
- dout_sop  out  1  first header byte.
- dout_eop  out  1  last payload byte.
- dout_rdy  in  1  sink ready; a byte transfers when dout_vld && dout_rdy.
- drop_cnt  out  16  count of dropped packets, saturating at 0xFFFF.

## Operation
- Ingress states: WAIT_SOP, ACCEPT, DISCARD.
  - WAIT_SOP: din_vld without sop is ignored.
  - At sop, the packet is admitted only if payload FIFO free ≥ MAX_LEN and the descriptor FIFO is not full. Admitted packets go to ACCEPT; others go to DISCARD and drop_cnt increments.
- ACCEPT writes {eop, byte} to the payload FIFO at the speculative write pointer and counts len.
  - Checksum accumulator, 32-bit: payload is summed as big-endian 16-bit words. Byte k even is the high byte. An odd final byte is padded with a low byte of 0x00.
  - On eop: commit pointer := write pointer, then write descriptor {ports, IPs, len, sum} and return to WAIT_SOP.
- Abort with rollback:
  - If byte MAX_LEN+1 arrives, or a sop arrives while in ACCEPT, write pointer := commit pointer and drop_cnt increments.
  - Oversize packets then move to DISCARD until eop.
  - A mid-packet sop is treated as a new sop and re-evaluated for admission in the same cycle.
- DISCARD: bytes are ignored; eop returns to WAIT_SOP.
- The payload FIFO read side sees only committed data (empty is derived from the commit pointer).
- udp_len = len + 8, 16-bit.
- Checksum total = sum + sour_ip[31:16] + sour_ip[15:0] + dest_ip[31:16] + dest_ip[15:0] + 0x0011 + udp_len + sour_port + dest_port + udp_len.
  - Fold carries twice into 16 bits, then take the one's complement.
  - A result of 0x0000 is sent as 0xFFFF.
  - With CSUM_EN=0 the field is 0x0000.
- Egress states: IDLE, HEAD, PAY.
  - IDLE: go to HEAD when the descriptor FIFO is non-empty.
  - HEAD: send 8 bytes, big-endian: sport hi/lo, dport hi/lo, len hi/lo, csum hi/lo.
  - PAY: send len bytes from the payload FIFO, then pop the descriptor. Go to HEAD if another descriptor is pending, else IDLE.
- dout_sop is high with header byte 0 only. dout_eop is high with the last payload byte only.

## Timing
- Reset values: dout=0x00, dout_vld=0, dout_sop=0, dout_eop=0, drop_cnt=0. Both FIFOs are empty and both FSMs are idle (WAIT_SOP / IDLE).
- An asynchronous rst mid-packet discards all buffered and partial data immediately.
- Output register behaviour:
  - All outputs are registered.
  - While dout_vld && !dout_rdy, dout, dout_sop and dout_eop are held stable.
  - Throughput is 1 byte/cycle when dout_rdy=1.
- Latency: eop accepted at cycle T, descriptor visible at T+1, first header dout_vld at T+2 when egress is idle.
- Back-to-back packets need no gap on egress: the next header byte may follow dout_eop on the next cycle.
- Ingress eop and egress descriptor pop in the same cycle are both honoured; the FIFO count is unchanged.
- Pointers wrap modulo DATA_DEPTH and MSG_DEPTH.
- drop_cnt updates the cycle after the abort or drop decision.

## Test plan
1. sport=0x1234, dport=0x5678, sip=0xC0A80001, dip=0xC0A80002, payload 01 02 03 04, dout_rdy=1 -> output 12 34 56 78 00 0C 11 D0 01 02 03 04; sop on 0x12, eop on 0x04; first vld at T+2.
2. Same headers, 1-byte payload AB -> output 12 34 56 78 00 09 6A DB AB (odd-byte padding).
3. Case 1 with dout_rdy toggling 1,0,1,0 -> identical byte sequence; dout stable during every stall cycle.
4. MAX_LEN=16, 20-byte packet followed by a 4-byte packet -> only the case 1 output appears; drop_cnt=1.
5. sop, 3 bytes, then a new sop starting the case 1 payload -> only the case 1 output appears; drop_cnt=1.
6. dout_rdy=0, MSG_DEPTH+1 one-byte packets, then dout_rdy=1 -> MSG_DEPTH packets out in order, drop_cnt=1. CSUM_EN=0 run -> bytes 7-8 are 00 00.
